lcd_capture: RTL
================

# lcd_capture

Receive-side counterpart of the LCD timing driver: samples a DE-mode parallel RGB video stream (de, active-low hsync/vsync, 24-bit pixel), reconstructs pixel coordinates, crops a programmable window and forwards pixels through a 4-entry FIFO on a valid/ready stream toward the frame-buffer writer. It also measures line length and active line count per frame and flags format and overflow errors. Video input is synchronous to clk, with one pixel per clk cycle.

## Interface
- H_DISP, 800: expected active pixels per line.
- V_DISP, 480: expected active lines per frame.
- X_START, 0: crop window first column, in active-area coordinates.
- X_ZOOM, 640: crop window width.
- Y_START, 0: crop window first row.
- Y_ZOOM, 480: crop window height.

Ports:
- clk  in  1  pixel clock. Single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable. Sampled only at frame boundaries.
- clr_err  in  1  synchronous clear of sticky error flags.
- vid_de  in  1  data enable. 1 means an active pixel.
- vid_hsync  in  1  line sync, low during the sync pulse.
- vid_vsync  in  1  frame sync, low during the sync pulse.
- vid_rgb  in  24  pixel data.
- pix_valid  out  1  FIFO head valid.
- pix_ready  in  1  downstream accept.
- pix_data  out  24  pixel.
- pix_x  out  11  column relative to the crop window.
- pix_y  out  11  row relative to the crop window.
- pix_sof  out  1  first pixel of window: x=0, y=0.
- pix_eol  out  1  last pixel of a window row: x=X_ZOOM-1.
- frame_done  out  1  one-cycle pulse at frame end.
- h_meas  out  11  length of the last completed active line.
- v_meas  out  11  active lines in the last completed frame.
- err_format  out  1  sticky: line or frame length mismatch.
- err_overflow  out  1  sticky: pixel dropped because the FIFO was full.

## Operation
- Input stage: all vid_* signals are registered once. Edge detection on vsync, hsync and de uses the registered copy versus its previous value. hsync is used only for its monitoring role and does not advance counters; de alone delimits pixels.
- State machine:
  - IDLE: wait for a vsync falling edge. Go to VSYNC if enable=1, otherwise stay in IDLE.
  - VSYNC: wait for a vsync rising edge, then go to FRAME and clear x and y to 0.
  - FRAME:
    - Each registered de=1 cycle is one pixel at (x, y). x then increments.
    - On a de falling edge: h_meas<=x; if x!=H_DISP set err_format; y increments; x clears.
    - On a vsync falling edge: v_meas<=y; if y!=V_DISP set err_format; pulse frame_done. Go to VSYNC if enable=1, otherwise go to IDLE.
- de activity outside FRAME is ignored.
- x and y saturate at 2047. Saturation sets err_format.
- Crop: a pixel is written to the FIFO only if X_START<=x<X_START+X_ZOOM and Y_START<=y<Y_START+Y_ZOOM. Stored coordinates are x-X_START and y-Y_START. sof and eol are computed at write time.
- FIFO:
  - 4 entries, each 48 bits: rgb, x, y, sof, eol. First-word fall-through.
  - A pop occurs when pix_valid&&pix_ready.
  - A write while full is accepted if a pop happens in the same cycle. Otherwise the pixel is dropped and err_overflow is set.
  - The FIFO is never flushed by frame boundaries.
- Error flags: clr_err clears both flags. If clr_err and a new error occur in the same cycle, the error wins and the flag stays 1.
- Disabling enable mid-frame has no effect until the frame ends.

## Timing
- Reset values: state IDLE; all outputs 0, including pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, frame_done, h_meas, v_meas and both error flags. FIFO is empty.
- Latency: a vid sample present at clk edge N is captured at N, written to the FIFO at N+1, and shows pix_valid=1 after N+1 if the FIFO was empty. This is 2 cycles input to output.
- frame_done is asserted for the cycle after the registered vsync falling edge is detected. h_meas and v_meas update on the same edge as their respective detecting edge.
- pix_data, pix_x, pix_y, pix_sof and pix_eol hold stable while pix_valid=1 and pix_ready=0.
- A reset mid-frame aborts immediately. The partial frame is discarded and capture resumes only after the next complete vsync pulse.

## Test plan
- Nominal 800x480 frame with enable=1 and pix_ready=1 held high -> exactly 640x480 pixels out. The first has sof=1 and pixel (0,0). The last is (639,479) with eol=1. frame_done pulses once; h_meas=800, v_meas=480, no errors.
- Crop X_START=100, X_ZOOM=4, Y_START=2, Y_ZOOM=1 with a pixel ramp rgb=x -> exactly 4 pixels out: rgb 100..103 with pix_x 0..3 and pix_y 0; eol only on the last.
- Backpressure: pix_ready=0 for the whole first window row -> 4 pixels buffered, then the rest dropped and err_overflow=1. Pulsing clr_err clears the flag. A full FIFO with pix_ready=1 on the same cycle as a write -> no drop.
- Malformed frame with one line of 799 pixels and 479 lines -> err_format=1, h_meas=799 after that line, v_meas=479.
- enable deasserted mid-frame -> the current frame completes, then the block sits in IDLE with no output. Re-enabling starts capture at the next full vsync pulse, not mid-frame.
- rst_n asserted during line 200 -> all outputs 0 immediately. The next partial frame produces no pixels, and the following frame is captured correctly.

Source files
------------

// File: rtl/lcd_capture.sv
// lcd_capture: receive side of a DE-mode parallel RGB video link.
// Registers the incoming video and rebuilds (x, y) pixel coordinates from
// de and vsync. Pixels inside a programmable crop window go through a
// 4-entry first-word-fall-through FIFO to a valid/ready stream. The block
// also measures line length and line count, and keeps sticky error flags.
//
// Ports
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   enable            capture enable, looked at only on vsync falling edges
//   clr_err           synchronous clear of err_format / err_overflow
//   vid_de/hsync/vsync/rgb  video input (syncs active low)
//   pix_valid/ready   output stream handshake
//   pix_data/x/y/sof/eol    FIFO head: pixel, window coordinates, markers
//   frame_done        one-cycle pulse when a captured frame ends
//   h_meas, v_meas    last completed line length / active line count
//   err_format        sticky line/frame length mismatch or counter saturation
//   err_overflow      sticky pixel dropped on a full FIFO
module lcd_capture #(
   parameter int H_DISP  = 800,
   parameter int V_DISP  = 480,
   parameter int X_START = 0,
   parameter int X_ZOOM  = 640,
   parameter int Y_START = 0,
   parameter int Y_ZOOM  = 480
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        clr_err,
   input  logic        vid_de,
   input  logic        vid_hsync,
   input  logic        vid_vsync,
   input  logic [23:0] vid_rgb,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [23:0] pix_data,
   output logic [10:0] pix_x,
   output logic [10:0] pix_y,
   output logic        pix_sof,
   output logic        pix_eol,
   output logic        frame_done,
   output logic [10:0] h_meas,
   output logic [10:0] v_meas,
   output logic        err_format,
   output logic        err_overflow
);

   typedef struct packed {
      logic [23:0] rgb;
      logic [10:0] x;
      logic [10:0] y;
      logic        sof;
      logic        eol;
   } pix_t;

   typedef enum logic [1:0] {S_IDLE, S_VSYNC, S_FRAME} state_t;

   localparam logic [11:0] HD   = 12'(H_DISP);
   localparam logic [11:0] VD   = 12'(V_DISP);
   localparam logic [11:0] XS   = 12'(X_START);
   localparam logic [11:0] YS   = 12'(Y_START);
   localparam logic [11:0] XZ   = 12'(X_ZOOM);
   localparam logic [11:0] YZ   = 12'(Y_ZOOM);
   localparam logic [11:0] XZL  = 12'(X_ZOOM - 1);
   localparam logic [10:0] CMAX = 11'h7FF;

   // ---------------- input stage ----------------
   logic        de_r, hs_r, vs_r, de_p, vs_p;
   logic [23:0] rgb_r;

   // Syncs reset to their inactive (high) level so leaving reset never
   // looks like a sync edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_r  <= 1'b0;
         hs_r  <= 1'b1;
         vs_r  <= 1'b1;
         rgb_r <= '0;
         de_p  <= 1'b0;
         vs_p  <= 1'b1;
      end else begin
         de_r  <= vid_de;
         hs_r  <= vid_hsync;
         vs_r  <= vid_vsync;
         rgb_r <= vid_rgb;
         de_p  <= de_r;
         vs_p  <= vs_r;
      end
   end

   // Line boundaries come from de alone; hsync is registered for alignment
   // with the other video signals and for monitoring only.
   logic unused_hs;
   assign unused_hs = hs_r;

   logic vs_fall, vs_rise, de_fall;
   assign vs_fall = vs_p & ~vs_r;
   assign vs_rise = ~vs_p & vs_r;
   assign de_fall = de_p & ~de_r;

   // ---------------- coordinate tracking ----------------
   state_t      state;
   logic [10:0] x, y;

   // Window-relative coordinates; bit 12 is the borrow (coordinate before
   // the window start).
   logic [12:0] xd, yd;
   logic        in_win;
   assign xd     = {2'b00, x} - {1'b0, XS};
   assign yd     = {2'b00, y} - {1'b0, YS};
   assign in_win = !xd[12] && (xd[11:0] < XZ) && !yd[12] && (yd[11:0] < YZ);

   logic in_frame, wr_req, fmt_set;
   assign in_frame = (state == S_FRAME);
   assign wr_req   = in_frame && !vs_fall && de_r && in_win;

   always_comb begin
      fmt_set = 1'b0;
      if (in_frame) begin
         if (vs_fall)      fmt_set = ({1'b0, y} != VD);
         else if (de_r)    fmt_set = (x == CMAX);
         else if (de_fall) fmt_set = ({1'b0, x} != HD) || (y == CMAX);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         x          <= '0;
         y          <= '0;
         h_meas     <= '0;
         v_meas     <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_IDLE:  if (vs_fall && enable) state <= S_VSYNC;
            S_VSYNC: if (vs_rise) begin
               state <= S_FRAME;
               x     <= '0;
               y     <= '0;
            end
            S_FRAME: begin
               if (vs_fall) begin
                  v_meas     <= y;
                  frame_done <= 1'b1;
                  state      <= enable ? S_VSYNC : S_IDLE;
               end else if (de_r) begin
                  if (x != CMAX) x <= x + 11'd1;
               end else if (de_fall) begin
                  h_meas <= x;
                  x      <= '0;
                  if (y != CMAX) y <= y + 11'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // ---------------- output FIFO ----------------
   pix_t       mem [4];
   logic [1:0] wp, rp;
   logic [2:0] cnt;
   logic       pop, push, drop, full;
   pix_t       wdata, head;

   assign full  = (cnt == 3'd4);
   assign pop   = (cnt != 3'd0) && pix_ready;
   // A full FIFO still takes the write when the head leaves the same cycle.
   assign push  = wr_req && (!full || pop);
   assign drop  = wr_req && full && !pop;

   assign wdata = '{rgb: rgb_r,
                    x:   xd[10:0],
                    y:   yd[10:0],
                    sof: (xd[11:0] == 12'd0) && (yd[11:0] == 12'd0),
                    eol: (xd[11:0] == XZL)};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) mem[i] <= '0;
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) begin
            mem[wp] <= wdata;
            wp      <= wp + 2'd1;
         end
         if (pop) rp <= rp + 2'd1;
         if (push && !pop)      cnt <= cnt + 3'd1;
         else if (!push && pop) cnt <= cnt - 3'd1;
      end
   end

   assign head      = mem[rp];
   assign pix_valid = (cnt != 3'd0);
   assign pix_data  = head.rgb;
   assign pix_x     = head.x;
   assign pix_y     = head.y;
   assign pix_sof   = head.sof;
   assign pix_eol   = head.eol;

   // ---------------- sticky errors: a new error beats clr_err ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_format   <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         if (fmt_set)      err_format <= 1'b1;
         else if (clr_err) err_format <= 1'b0;
         if (drop)         err_overflow <= 1'b1;
         else if (clr_err) err_overflow <= 1'b0;
      end
   end

endmodule
